// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word
// fetches and hands (instruction, pc) pairs to decode over valid/ready.
// PC redirects come from debug, interrupt and branch requests.
module fetch_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        irq_i,
  input  logic        drq_i,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  input  logic        if_ack_i,
  input  logic [31:0] if_data_i,
  output logic        output_valid_o,
  input  logic        output_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);
  // ecap5_dproc_pkg address map
  localparam logic [31:0] BOOT_ADDRESS      = 32'h0000_0000;
  localparam logic [31:0] INTERRUPT_ADDRESS = 32'hFF00_000A;
  localparam logic [31:0] DEBUG_ADDRESS     = 32'hFF00_000B;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_pending, w_pending_nxt;
  logic [1:0]  r_pend_prio, w_pend_prio_nxt;   // 3=debug 2=irq 1=branch
  logic [31:0] r_pend_target, w_pend_target_nxt;

  logic        w_event;
  logic [1:0]  w_event_prio;
  logic [31:0] w_event_target;
  logic        w_redirect;
  logic [31:0] w_target;

  // Highest-priority new event this cycle; lower ones are dropped
  always_comb begin
    w_event_prio   = 2'd0;
    w_event_target = 32'h0;
    if (drq_i) begin
      w_event_prio   = 2'd3;
      w_event_target = DEBUG_ADDRESS;
    end else if (irq_i) begin
      w_event_prio   = 2'd2;
      w_event_target = INTERRUPT_ADDRESS;
    end else if (branch_i) begin
      w_event_prio   = 2'd1;
      w_event_target = branch_target_i;
    end
  end

  assign w_event    = drq_i | irq_i | branch_i;
  assign w_redirect = w_event | r_pending;
  assign w_target   = w_event ? w_event_target : r_pend_target;

  // Next-state and next-output computation
  always_comb begin
    w_state_nxt       = r_state;
    w_req_nxt         = r_req;
    w_addr_nxt        = r_addr;
    w_valid_nxt       = r_valid;
    w_instr_nxt       = r_instr;
    w_pc_nxt          = r_pc;
    w_pending_nxt     = r_pending;
    w_pend_prio_nxt   = r_pend_prio;
    w_pend_target_nxt = r_pend_target;
    case (r_state)
      S_IDLE: begin
        if (w_redirect) begin
          w_addr_nxt      = w_target;
          w_pending_nxt   = 1'b0;
          w_pend_prio_nxt = 2'd0;
        end
        w_req_nxt   = 1'b1;
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (if_ack_i) begin
          w_req_nxt = 1'b0;
          if (w_redirect) begin
            // fetched word belongs to the abandoned path
            w_addr_nxt      = w_target;
            w_pending_nxt   = 1'b0;
            w_pend_prio_nxt = 2'd0;
            w_state_nxt     = S_IDLE;
          end else begin
            w_instr_nxt = if_data_i;
            w_pc_nxt    = r_addr;
            w_valid_nxt = 1'b1;
            w_addr_nxt  = r_addr + 32'd4;
            w_state_nxt = S_OUT;
          end
        end else if (w_event && (!r_pending || w_event_prio >= r_pend_prio)) begin
          // address must stay stable while the request is outstanding
          w_pending_nxt     = 1'b1;
          w_pend_prio_nxt   = w_event_prio;
          w_pend_target_nxt = w_event_target;
        end
      end
      S_OUT: begin
        if (w_redirect) begin
          w_valid_nxt = 1'b0;
          w_addr_nxt  = w_target;
          w_state_nxt = S_IDLE;
        end else if (output_ready_i) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_req         <= 1'b0;
      r_addr        <= BOOT_ADDRESS;
      r_valid       <= 1'b0;
      r_instr       <= 32'h0;
      r_pc          <= 32'h0;
      r_pending     <= 1'b0;
      r_pend_prio   <= 2'd0;
      r_pend_target <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_req         <= w_req_nxt;
      r_addr        <= w_addr_nxt;
      r_valid       <= w_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_pc          <= w_pc_nxt;
      r_pending     <= w_pending_nxt;
      r_pend_prio   <= w_pend_prio_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

  assign if_req_o       = r_req;
  assign if_addr_o      = r_addr;
  assign output_valid_o = r_valid;
  assign instr_o        = r_instr;
  assign pc_o           = r_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, checked
// by a scoreboard fed from a transaction-level reference model.
module tb_fetch_stage;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        branch_i = 1'b0, irq_i = 1'b0, drq_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        if_ack_i = 1'b0;
  logic [31:0] if_data_i = 32'h0;
  logic        output_ready_i = 1'b0;
  logic        if_req_o, output_valid_o;
  logic [31:0] if_addr_o, instr_o, pc_o;

  fetch_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .irq_i(irq_i), .drq_i(drq_i),
    .if_req_o(if_req_o), .if_addr_o(if_addr_o),
    .if_ack_i(if_ack_i), .if_data_i(if_data_i),
    .output_valid_o(output_valid_o), .output_ready_i(output_ready_i),
    .instr_o(instr_o), .pc_o(pc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = waiting to fetch, 1 = fetch outstanding,
  // 2 = holding an instruction for decode
  int          m_phase;
  logic [31:0] m_pc;          // address of the current/next fetch
  int          m_pend_lvl;    // 0 none, 1 branch, 2 irq, 3 debug
  logic [31:0] m_pend_tgt;
  logic [31:0] m_out_instr, m_out_pc;
  logic [31:0] exp_fetch[$];
  logic [63:0] exp_out[$];

  task automatic model_reset();
    m_phase = 0; m_pc = 32'h0; m_pend_lvl = 0; m_pend_tgt = 32'h0;
    m_out_instr = 32'h0; m_out_pc = 32'h0;
    exp_fetch.delete(); exp_out.delete();
  endtask

  // One clock edge of the model, using the inputs presented at that edge
  task automatic model_step();
    int          lvl;
    logic [31:0] ev_tgt, tgt;
    bit          redir;
    lvl = drq_i ? 3 : irq_i ? 2 : branch_i ? 1 : 0;
    ev_tgt = drq_i ? 32'hFF00000B : irq_i ? 32'hFF00000A : branch_target_i;
    redir = (lvl != 0) || (m_pend_lvl != 0);
    tgt = (lvl != 0) ? ev_tgt : m_pend_tgt;
    if (m_phase == 0) begin
      if (redir) begin m_pc = tgt; m_pend_lvl = 0; end
      exp_fetch.push_back(m_pc);
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (if_ack_i) begin
        if (redir) begin
          m_pc = tgt; m_pend_lvl = 0; m_phase = 0;
        end else begin
          m_out_instr = if_data_i; m_out_pc = m_pc;
          exp_out.push_back({if_data_i, m_pc});
          m_pc = m_pc + 32'd4;
          m_phase = 2;
        end
      end else if (lvl != 0 && lvl >= m_pend_lvl) begin
        m_pend_lvl = lvl; m_pend_tgt = ev_tgt;
      end
    end else begin
      if (redir) begin m_pc = tgt; m_phase = 0; end
      else if (output_ready_i) m_phase = 0;
    end
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge
  initial begin : monitor
    logic        prev_req, prev_vld;
    logic [31:0] e;
    logic [63:0] eo;
    prev_req = 1'b0; prev_vld = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_req = 1'b0; prev_vld = 1'b0;
      end else begin
        chk("if_req_o", {31'h0, if_req_o}, {31'h0, m_phase == 1});
        chk("output_valid_o", {31'h0, output_valid_o}, {31'h0, m_phase == 2});
        if (if_req_o && !prev_req) begin
          if (exp_fetch.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL fetch_start: unexpected request at %h", if_addr_o);
          end else begin
            e = exp_fetch.pop_front();
            chk("fetch_addr", if_addr_o, e);
          end
        end
        if (if_req_o) chk("fetch_addr_hold", if_addr_o, m_pc);
        if (output_valid_o && !prev_vld) begin
          if (exp_out.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL out_start: unexpected valid instr %h pc %h", instr_o, pc_o);
          end else begin
            eo = exp_out.pop_front();
            chk("out_instr", instr_o, eo[63:32]);
            chk("out_pc", pc_o, eo[31:0]);
          end
        end
        if (output_valid_o) begin
          chk("instr_hold", instr_o, m_out_instr);
          chk("pc_hold", pc_o, m_out_pc);
        end
        prev_req = if_req_o; prev_vld = output_valid_o;
      end
    end
  end

  task automatic cycle(input bit d, input bit i, input bit b, input logic [31:0] t,
                       input bit ack, input logic [31:0] data, input bit rdy);
    drq_i = d; irq_i = i; branch_i = b; branch_target_i = t;
    if_ack_i = ack; if_data_i = data; output_ready_i = rdy;
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic nop(input bit rdy);
    cycle(0, 0, 0, 32'h0, 0, 32'h0, rdy);
  endtask

  task automatic ack(input logic [31:0] data);
    cycle(0, 0, 0, 32'h0, 1, data, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst if_req_o", {31'h0, if_req_o}, 32'h0);
    chk("rst if_addr_o", if_addr_o, 32'h0);
    chk("rst output_valid_o", {31'h0, output_valid_o}, 32'h0);
    chk("rst instr_o", instr_o, 32'h0);
    chk("rst pc_o", pc_o, 32'h0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_vals();
    rst_i = 1'b0;

    // first fetch from boot address, zero-wait ack
    nop(1);
    chk("first req", {31'h0, if_req_o}, 32'h1);
    chk("first addr", if_addr_o, 32'h0);
    cycle(0, 0, 0, 32'h0, 1, 32'h00000013, 0);
    chk("first valid", {31'h0, output_valid_o}, 32'h1);
    chk("first instr", instr_o, 32'h00000013);
    chk("first pc", pc_o, 32'h0);

    // decode stalls for 5 cycles
    for (int k = 0; k < 5; k++) begin
      nop(0);
      chk("stall instr", instr_o, 32'h00000013);
      chk("stall req", {31'h0, if_req_o}, 32'h0);
    end
    nop(1);
    chk("ready drops valid", {31'h0, output_valid_o}, 32'h0);
    nop(1);
    chk("second addr", if_addr_o, 32'h4);
    ack(32'hAAAA0004);
    nop(1);
    nop(1);
    chk("third addr", if_addr_o, 32'h8);

    // branch while waiting for a slow ack
    nop(1);
    cycle(0, 0, 1, 32'h100, 0, 32'h0, 1);
    nop(1);
    ack(32'hDEAD0008);
    chk("discard valid", {31'h0, output_valid_o}, 32'h0);
    nop(1);
    chk("branch addr", if_addr_o, 32'h100);

    // irq + branch together while holding output
    cycle(0, 0, 0, 32'h0, 1, 32'h11110100, 0);
    cycle(0, 1, 1, 32'h200, 0, 32'h0, 0);
    chk("flush valid", {31'h0, output_valid_o}, 32'h0);
    nop(1);
    chk("irq addr", if_addr_o, 32'hFF00000A);
    cycle(0, 0, 0, 32'h0, 1, 32'h2222000A, 0);
    cycle(1, 1, 0, 32'h0, 0, 32'h0, 0);
    nop(1);
    chk("dbg addr", if_addr_o, 32'hFF00000B);

    // irq pending, then debug before the ack
    cycle(0, 1, 0, 32'h0, 0, 32'h0, 1);
    cycle(1, 0, 0, 32'h0, 0, 32'h0, 1);
    ack(32'h3333000B);
    nop(1);
    chk("pending dbg addr", if_addr_o, 32'hFF00000B);

    // asynchronous reset while a request is outstanding
    #2;
    rst_i = 1'b1; if_ack_i = 1'b1; if_data_i = 32'hBAD0BAD0;
    #1;
    chk_reset_vals();
    model_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    chk_reset_vals();
    rst_i = 1'b0; if_ack_i = 1'b0;
    nop(1);
    chk("restart addr", if_addr_o, 32'h0);

    // address wraps modulo 2^32
    cycle(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0, 1);
    ack(32'h44440000);
    nop(1);
    chk("wrap fetch", if_addr_o, 32'hFFFFFFFC);
    ack(32'h5555FFFC);
    chk("wrap pc", pc_o, 32'hFFFFFFFC);
    nop(1);
    nop(1);
    chk("wrap next", if_addr_o, 32'h0);

    // random traffic, including acks while no request is outstanding
    for (int k = 0; k < 3000; k++) begin
      bit d, i, b, a, r;
      d = ($urandom % 20) == 0;
      i = ($urandom % 16) == 0;
      b = ($urandom % 10) == 0;
      a = (m_phase == 1) ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
      r = ($urandom % 2) == 0;
      cycle(d, i, b, $urandom, a, $urandom, r);
    end
    nop(1);
    @(negedge clk_i); #1;
    chk("fetch queue drained", exp_fetch.size(), 32'h0);
    chk("output queue drained", exp_out.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage, first stage of the ECAP5-DPROC pipeline, directly upstream of decode. It owns the program counter and issues word fetches on a single-outstanding req/ack instruction-memory interface. It delivers (instruction, pc) pairs to decode over a valid/ready handshake. It redirects the PC on branch, interrupt and debug requests, using the ecap5_dproc_pkg constants BOOT_ADDRESS = 0x00000000, INTERRUPT_ADDRESS = 0xFF00000A and DEBUG_ADDRESS = 0xFF00000B.

Parameters:
None. All addresses come from ecap5_dproc_pkg.

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset, asynchronous, active-high
branch_i  in  1  branch-taken pulse from execute
branch_target_i  in  32  branch target; valid when branch_i=1
irq_i  in  1  interrupt request pulse
drq_i  in  1  debug request pulse
if_req_o  out  1  fetch request
if_addr_o  out  32  fetch address
if_ack_i  in  1  fetch acknowledge; if_data_i valid in the same cycle
if_data_i  in  32  fetched instruction word
output_valid_o  out  1  instruction available to decode
output_ready_i  in  1  decode accepts
instr_o  out  32  instruction to decode
pc_o  out  32  address of instr_o

Behaviour:
- All outputs are registered.
- Reset values, applied asynchronously while rst_i=1: state=S_IDLE, if_req_o=0, if_addr_o=BOOT_ADDRESS, output_valid_o=0, instr_o=0, pc_o=0, pending=0, pending_target=0.
- Redirect selection each cycle, highest priority first: drq_i → DEBUG_ADDRESS; irq_i → INTERRUPT_ADDRESS; branch_i → branch_target_i; pending=1 → pending_target. Lower-priority sources in the same cycle are dropped.
- If none of these is active, the next PC is if_addr_o+4, wrapping modulo 2^32. No alignment check is performed.
- if_ack_i is ignored whenever if_req_o=0.
- S_IDLE:
  - if_req_o=0.
  - Next edge: if a redirect is selected, if_addr_o<=selected target and pending<=0; otherwise if_addr_o is unchanged.
  - Next edge: if_req_o<=1, go to S_REQ.
- S_REQ:
  - if_req_o=1. if_addr_o is held stable until ack; it never changes while a request is outstanding.
  - A new drq_i/irq_i/branch_i while in S_REQ loads pending<=1, pending_target<=its target. A higher-or-equal priority event replaces an existing pending target; a lower-priority event is dropped. Track the pending priority with a 2-bit register.
  - Ack with no redirect (pending=0 and no new event that cycle):
    - instr_o<=if_data_i, pc_o<=if_addr_o, output_valid_o<=1
    - if_addr_o<=if_addr_o+4, if_req_o<=0
    - go to S_OUT
  - Ack with a redirect (pending=1 or a new event that cycle):
    - if_data_i is discarded; output_valid_o stays 0
    - if_addr_o<=selected target, pending<=0, if_req_o<=0
    - go to S_IDLE
- S_OUT:
  - output_valid_o=1; instr_o and pc_o are held stable while output_ready_i=0.
  - A transfer occurs on any edge with output_valid_o=1 and output_ready_i=1.
  - Redirect this cycle: output_valid_o<=0 and if_addr_o<=target (the instruction is flushed; if output_ready_i=1 the transfer still counts). Go to S_IDLE.
  - Else, on output_ready_i=1: output_valid_o<=0, go to S_IDLE.
  - Else stay in S_OUT.
- Latency and throughput:
  - First request is asserted on the 1st edge after rst_i deasserts.
  - With zero-wait ack and output_ready_i=1: the data edge sets output_valid_o; one instruction per 3 cycles (S_IDLE, S_REQ, S_OUT).
- Reset mid-operation: outputs return to reset values immediately; an outstanding ack is ignored; fetch restarts at BOOT_ADDRESS.
- Simultaneous ack + new redirect in S_REQ: the redirect wins and the data is dropped.
- Simultaneous drq_i + irq_i + branch_i: debug wins; the others are lost, not queued.

Test Plan:
- Release reset, ack 1 cycle after req with if_data_i=0x00000013 → if_addr_o=0x0 on first req; output_valid_o=1, instr_o=0x00000013, pc_o=0x0; next req at if_addr_o=0x4.
- Hold output_ready_i=0 for 5 cycles after output_valid_o=1 → instr_o/pc_o stable, if_req_o=0 throughout; ready=1 → valid drops next edge, next req at pc+4.
- Req at 0x8 with ack delayed 3 cycles; pulse branch_i with target 0x100 during the wait → 0x8 data discarded, output_valid_o never rises for it, next req at 0x100.
- Same-cycle irq_i + branch_i (target 0x200) in S_OUT → valid drops, next req 0xFF00000A; repeat with drq_i + irq_i → 0xFF00000B.
- irq_i pending in S_REQ, then drq_i before ack → after ack, next req 0xFF00000B.
- Assert rst_i asynchronously while req outstanding, then ack → all outputs reset immediately, ack ignored, first req after release at 0x00000000.
